cd_config_multi: RTL and testbench

- Parametrised successor of the two-channel clock-divider configuration block. Serves NUM_CH divider channels, for example UART baud, VGA pixel and future peripherals.
- Decodes config-bus writes into per-channel divider limits taken from a shared code-to-limit table.
- Holds each new limit as pending and commits it only on that channel's divider wrap pulse, so the divider never sees a mid-period change.
- Sits between the config bus and the clock-divider counters.

---
 rtl/cd_config_multi_pkg.sv | 44 ++++
 rtl/cd_config_multi_if.sv | 27 ++
 rtl/cd_cfg_channel.sv | 91 +++++++++
 rtl/cd_config_multi.sv | 91 +++++++++
 tb/tb_cd_config_multi.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cd_config_multi_pkg.sv
// Shared definitions for the multi-channel clock-divider configuration block:
// address map, code names, default limit table and reset codes, width helper.
package cd_config_multi_pkg;

    localparam int unsigned CLR_ERR_ADDR = 0;
    localparam int unsigned CH_BASE_ADDR = 1;

    localparam int unsigned DEF_NUM_CH            = 4;
    localparam int unsigned DEF_WIDTH_CONFIG_ADDR = 4;
    localparam int unsigned DEF_WIDTH_CONFIG_DATA = 8;
    localparam int unsigned DEF_WIDTH_CODE        = 3;
    localparam int unsigned DEF_NUM_CODES         = 8;
    localparam int unsigned DEF_WIDTH_LIMIT       = 16;
    localparam int unsigned DEF_TIMEOUT           = 1023;

    // Packed concatenations: the leftmost element lands in the highest slot.
    localparam logic [DEF_NUM_CODES*DEF_WIDTH_LIMIT-1:0] DEF_LIMIT_TABLE = {
        16'd0, 16'd1, 16'd446, 16'd868, 16'd2604, 16'd5208, 16'd10416, 16'd20832
    };
    localparam logic [DEF_NUM_CH*DEF_WIDTH_CODE-1:0] DEF_RESET_CODES = {
        3'd2, 3'd6, 3'd2, 3'd2
    };

    typedef enum logic [2:0] {
        CODE_20832 = 3'd0,
        CODE_10416 = 3'd1,
        CODE_5208  = 3'd2,
        CODE_2604  = 3'd3,
        CODE_868   = 3'd4,
        CODE_446   = 3'd5,
        CODE_1     = 3'd6,
        CODE_OFF   = 3'd7
    } cd_code_e;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } ch_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cd_config_multi_if.sv
// Config bus plus divider-side signals of the clock-divider configuration block.
interface cd_config_multi_if
    import cd_config_multi_pkg::*;
#(
    parameter int unsigned NUM_CH            = DEF_NUM_CH,
    parameter int unsigned WIDTH_CONFIG_ADDR = DEF_WIDTH_CONFIG_ADDR,
    parameter int unsigned WIDTH_CONFIG_DATA = DEF_WIDTH_CONFIG_DATA,
    parameter int unsigned WIDTH_LIMIT       = DEF_WIDTH_LIMIT
);
    logic [WIDTH_CONFIG_ADDR-1:0]  c_addr;
    logic [WIDTH_CONFIG_DATA-1:0]  c_data;
    logic                          c_valid;
    logic [NUM_CH-1:0]             div_wrap;
    logic [NUM_CH*WIDTH_LIMIT-1:0] limit;
    logic [NUM_CH-1:0]             ch_ready;
    logic                          cfg_err;

    modport master (
        output c_addr, c_data, c_valid, div_wrap,
        input  limit, ch_ready, cfg_err
    );

    modport slave (
        input  c_addr, c_data, c_valid, div_wrap,
        output limit, ch_ready, cfg_err
    );
endinterface

// File: rtl/cd_cfg_channel.sv
// One divider channel: IDLE/PEND FSM, pending and active limit registers.
// Optional forced commit after TIMEOUT PEND cycles with CD_CFG_WRAP_TIMEOUT_EN.
module cd_cfg_channel
    import cd_config_multi_pkg::*;
#(
    parameter int unsigned             WIDTH_LIMIT = DEF_WIDTH_LIMIT,
    parameter int unsigned             TIMEOUT     = DEF_TIMEOUT,
    parameter logic [WIDTH_LIMIT-1:0]  RESET_LIMIT = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH_LIMIT-1:0] wr_limit,
    input  logic                   wrap,
    output logic [WIDTH_LIMIT-1:0] limit,
    output logic                   ready
);
    ch_state_e              state_q, state_d;
    logic                   load_pend, commit, timeout_hit;
    logic [WIDTH_LIMIT-1:0] pend_q, limit_q;

`ifdef CD_CFG_WRAP_TIMEOUT_EN
    localparam int unsigned CW = cnt_width(TIMEOUT);
    logic [CW-1:0] cnt_q;

    // Restarted by every accepted write, including one that re-arms PEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_pend) begin
            cnt_q <= '0;
        end else if (state_q == CH_PEND) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == CH_PEND) && (cnt_q == CW'(TIMEOUT - 1));
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A write coinciding with a commit commits the old value first, then re-arms.
    always_comb begin
        state_d   = state_q;
        load_pend = 1'b0;
        commit    = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (wr_en) begin
                    load_pend = 1'b1;
                    state_d   = CH_PEND;
                end
            end
            CH_PEND: begin
                load_pend = wr_en;
                if (wrap || timeout_hit) begin
                    commit  = 1'b1;
                    state_d = wr_en ? CH_PEND : CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            limit_q <= RESET_LIMIT;
        end else begin
            if (commit) begin
                limit_q <= pend_q;
            end
            if (load_pend) begin
                pend_q <= wr_limit;
            end
        end
    end

    assign limit = limit_q;
    assign ready = (state_q == CH_IDLE);

endmodule

// File: rtl/cd_config_multi.sv
// Multi-channel clock-divider configuration: decodes config writes into
// per-channel limits committed on divider wrap. Option: CD_CFG_WRAP_TIMEOUT_EN.
module cd_config_multi
    import cd_config_multi_pkg::*;
#(
    parameter int unsigned                         NUM_CH            = DEF_NUM_CH,
    parameter int unsigned                         WIDTH_CONFIG_ADDR = DEF_WIDTH_CONFIG_ADDR,
    parameter int unsigned                         WIDTH_CONFIG_DATA = DEF_WIDTH_CONFIG_DATA,
    parameter int unsigned                         WIDTH_CODE        = DEF_WIDTH_CODE,
    parameter int unsigned                         NUM_CODES         = DEF_NUM_CODES,
    parameter int unsigned                         WIDTH_LIMIT       = DEF_WIDTH_LIMIT,
    parameter logic [NUM_CODES*WIDTH_LIMIT-1:0]    LIMIT_TABLE       = DEF_LIMIT_TABLE,
    parameter logic [NUM_CH*WIDTH_CODE-1:0]        RESET_CODES       = DEF_RESET_CODES,
    parameter int unsigned                         TIMEOUT           = DEF_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    cd_config_multi_if.slave cfg
);
    logic [WIDTH_CODE-1:0]         code;
    logic [WIDTH_LIMIT-1:0]        tbl_limit;
    logic                          code_ok;
    logic [31:0]                   addr_w;
    logic                          addr_is_ch, err_set, err_clr;
    logic [NUM_CH-1:0]             wr_en;
    logic [NUM_CH-1:0]             ready_w;
    logic [NUM_CH*WIDTH_LIMIT-1:0] limit_w;
    logic                          cfg_err_q;

    generate
        if (WIDTH_CONFIG_DATA > WIDTH_CODE) begin : g_data_hi
            logic unused_data_hi;
            assign unused_data_hi = ^cfg.c_data[WIDTH_CONFIG_DATA-1:WIDTH_CODE];
        end
    endgenerate

    // Codes beyond the table leave tbl_limit at zero, so one test covers both cases.
    always_comb begin
        code      = cfg.c_data[WIDTH_CODE-1:0];
        tbl_limit = '0;
        for (int unsigned i = 0; i < NUM_CODES; i++) begin
            if (code == WIDTH_CODE'(i)) begin
                tbl_limit = LIMIT_TABLE[i*WIDTH_LIMIT +: WIDTH_LIMIT];
            end
        end
        code_ok    = (tbl_limit != '0);
        addr_w     = 32'(cfg.c_addr);
        addr_is_ch = (addr_w >= CH_BASE_ADDR) && (addr_w < CH_BASE_ADDR + NUM_CH);
        err_set    = cfg.c_valid &&
                     ((addr_is_ch && !code_ok) || (addr_w >= CH_BASE_ADDR + NUM_CH));
        err_clr    = cfg.c_valid && (addr_w == CLR_ERR_ADDR);
        wr_en      = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            wr_en[k] = cfg.c_valid && code_ok && (addr_w == k + CH_BASE_ADDR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else if (err_set) begin
            cfg_err_q <= 1'b1;
        end else if (err_clr) begin
            cfg_err_q <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [WIDTH_CODE-1:0]  RC = RESET_CODES[k*WIDTH_CODE +: WIDTH_CODE];
        localparam logic [WIDTH_LIMIT-1:0] RL = LIMIT_TABLE[int'(RC)*WIDTH_LIMIT +: WIDTH_LIMIT];

        cd_cfg_channel #(
            .WIDTH_LIMIT (WIDTH_LIMIT),
            .TIMEOUT     (TIMEOUT),
            .RESET_LIMIT (RL)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[k]),
            .wr_limit (tbl_limit),
            .wrap     (cfg.div_wrap[k]),
            .limit    (limit_w[k*WIDTH_LIMIT +: WIDTH_LIMIT]),
            .ready    (ready_w[k])
        );
    end

    assign cfg.limit    = limit_w;
    assign cfg.ch_ready = ready_w;
    assign cfg.cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_cd_config_multi.sv
// Directed self-checking bench for cd_config_multi (default 4-channel table).
module tb_cd_config_multi;
    import cd_config_multi_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned WL  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cd_config_multi_if #(
        .NUM_CH            (NCH),
        .WIDTH_CONFIG_ADDR (4),
        .WIDTH_CONFIG_DATA (8),
        .WIDTH_LIMIT       (WL)
    ) bus ();

    cd_config_multi #(
        .NUM_CH  (NCH),
        .TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cfg (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lim(input int unsigned k);
        return 32'(bus.limit[k*WL +: WL]);
    endfunction

    // Called at a negedge; returns at the next negedge, after the capturing posedge.
    task automatic wr(input logic [3:0] addr, input logic [2:0] code);
        bus.c_addr  = addr;
        bus.c_data  = 8'(code);
        bus.c_valid = 1'b1;
        @(negedge clk);
        bus.c_valid = 1'b0;
    endtask

    task automatic wrap(input logic [3:0] mask);
        bus.div_wrap = mask;
        @(negedge clk);
        bus.div_wrap = '0;
    endtask

    initial begin
        int unsigned bad;
        int unsigned cnt;

        rst          = 1'b1;
        bus.c_addr   = '0;
        bus.c_data   = '0;
        bus.c_valid  = 1'b0;
        bus.div_wrap = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_lim0", lim(0), 5208);
        check_eq("rst_lim1", lim(1), 5208);
        check_eq("rst_lim2", lim(2), 1);
        check_eq("rst_lim3", lim(3), 5208);
        check_eq("rst_ready", bus.ch_ready, 4'hf);
        check_eq("rst_err", bus.cfg_err, 0);
        rst = 1'b0;
        @(negedge clk);

        wr(4'd1, CODE_868);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ch_ready[0] !== 1'b0 || lim(0) != 5208) bad++;
            @(negedge clk);
        end
        check_eq("pend_hold", bad, 0);
        wrap(4'b0001);
        check_eq("commit_lim0", lim(0), 868);
        check_eq("commit_rdy0", bus.ch_ready[0], 1);

        wr(4'd2, CODE_2604);
        check_eq("pend_rdy1", bus.ch_ready[1], 0);
        check_eq("pend_lim1", lim(1), 5208);
        bus.c_addr   = 4'd2;
        bus.c_data   = 8'(CODE_446);
        bus.c_valid  = 1'b1;
        bus.div_wrap = 4'b0010;
        @(negedge clk);
        bus.c_valid  = 1'b0;
        bus.div_wrap = '0;
        check_eq("wr_wrap_lim1", lim(1), 2604);
        check_eq("wr_wrap_rdy1", bus.ch_ready[1], 0);
        wrap(4'b0010);
        check_eq("second_lim1", lim(1), 446);
        check_eq("second_rdy1", bus.ch_ready[1], 1);

        wr(4'd3, CODE_OFF);
        check_eq("bad_code_err", bus.cfg_err, 1);
        check_eq("bad_code_lim2", lim(2), 1);
        check_eq("bad_code_rdy2", bus.ch_ready[2], 1);
        wr(4'd9, CODE_2604);
        check_eq("addr9_err", bus.cfg_err, 1);
        wr(4'd0, 3'd0);
        check_eq("clr_err", bus.cfg_err, 0);
        wr(4'd5, CODE_2604);
        check_eq("addr5_err", bus.cfg_err, 1);
        check_eq("addr5_lim3", lim(3), 5208);
        check_eq("addr5_ready", bus.ch_ready, 4'hf);
        wr(4'd0, 3'd0);
        check_eq("clr_err2", bus.cfg_err, 0);

        wrap(4'b1111);
        check_eq("idle_wrap_lim0", lim(0), 868);
        check_eq("idle_wrap_lim1", lim(1), 446);
        check_eq("idle_wrap_lim3", lim(3), 5208);
        check_eq("idle_wrap_ready", bus.ch_ready, 4'hf);

        wr(4'd1, CODE_20832);
        wr(4'd4, CODE_2604);
        check_eq("two_pend_ready", bus.ch_ready, 4'b0110);
        wrap(4'b1001);
        check_eq("both_lim0", lim(0), 20832);
        check_eq("both_lim3", lim(3), 2604);
        check_eq("both_ready", bus.ch_ready, 4'hf);

        wr(4'd3, CODE_868);
        wr(4'd3, CODE_5208);
        wrap(4'b0100);
        check_eq("last_wins_lim2", lim(2), 5208);

        wr(4'd4, CODE_868);
        check_eq("pre_rst_rdy3", bus.ch_ready[3], 0);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_lim3", lim(3), 5208);
        check_eq("async_rst_lim0", lim(0), 5208);
        check_eq("async_rst_ready", bus.ch_ready, 4'hf);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        wr(4'd1, CODE_446);
`ifdef CD_CFG_WRAP_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 20 && bus.ch_ready[0] === 1'b0; i++) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("timeout_cycles", cnt, 8);
        check_eq("timeout_lim0", lim(0), 446);
        check_eq("timeout_rdy0", bus.ch_ready[0], 1);
`else
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.ch_ready[0] === 1'b0) cnt++;
            @(negedge clk);
        end
        check_eq("no_timeout_cycles", cnt, 100);
        check_eq("no_timeout_lim0", lim(0), 5208);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
